logic_result_stage: RTL and testbench

- Registered consumer stage directly downstream of the 32-bit bitwise AND/OR units.
- Takes both unit outputs each beat and selects one result per an op code.
- Optionally chains the selected result with the previous result through an accumulator.
- Buffers results in a small valid/ready FIFO so the writeback/next stage can stall without losing data.

---
 rtl/logic_result_stage_pkg.sv | 21 ++
 rtl/logic_result_stage_if.sv | 41 ++++
 rtl/logic_result_stage_fifo.sv | 97 +++++++++
 rtl/logic_result_stage.sv | 94 +++++++++
 tb/tb_logic_result_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_result_stage_pkg.sv
// Shared definitions for the logic result stage: op encodings and default sizes.
package logic_stage_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;
    localparam int DEFAULT_CNT_W = 16;

    // Result select / chaining op codes presented alongside each beat.
    typedef enum logic [1:0] {
        OP_AND     = 2'b00,
        OP_OR      = 2'b01,
        OP_ACC_AND = 2'b10,
        OP_ACC_OR  = 2'b11
    } op_e;

    // Width of an occupancy count able to represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/logic_result_stage_if.sv
// Upstream beat / downstream result bus of the logic result stage.
// master = the surrounding pipeline (drives beats, consumes results),
// slave  = the stage itself.
interface logic_result_stage_if
    import logic_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) ();

    localparam int OCC_W = occ_width(DEPTH);

    // upstream beat
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] and_in;
    logic [WIDTH-1:0] or_in;

    // downstream result
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    // status
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] retired;

    modport master (
        output in_valid, op, and_in, or_in, out_ready,
        input  in_ready, out_valid, out_data, out_zero, occupancy, retired
    );

    modport slave (
        input  in_valid, op, and_in, or_in, out_ready,
        output in_ready, out_valid, out_data, out_zero, occupancy, retired
    );

endinterface

// File: rtl/logic_result_stage_fifo.sv
// Small register-based FIFO holding selected results until the next stage
// accepts them. Full/empty come from the occupancy count, not pointer compare,
// so pointers are plain modulo-DEPTH counters.
module result_fifo
    import logic_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic [occ_width(DEPTH)-1:0] occupancy,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] entry_rd [DEPTH];

    assign full    = (occ_q == OCC_W'(DEPTH));
    assign empty   = (occ_q == '0);
    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage: one reset-cleared register per entry so the head reads 0 after reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q, entry_d;

            // Capture the pushed word only in the slot the write pointer selects.
            always_comb begin
                entry_d = entry_q;
                if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = din;
                end
            end

            // Entry register with synchronous clear.
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entry_rd[gi] = entry_q;
        end
    endgenerate

    // Pointer and occupancy update; simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign dout      = entry_rd[rd_ptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/logic_result_stage.sv
// Registered consumer of the bitwise AND/OR units: selects one unit result per
// beat (optionally chained through an accumulator), queues it in a small FIFO
// and counts retired results. No combinational path from inputs to outputs.
module logic_result_stage
    import logic_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    logic_result_stage_if.slave   bus
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [WIDTH-1:0] res;
    logic             accept;
    logic             retire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic [OCC_W-1:0] fifo_occ;

    // in_ready depends only on stored occupancy, so a pop while full frees
    // the slot for the following cycle rather than the current one.
    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign accept        = bus.in_valid && !fifo_full;
    assign retire        = !fifo_empty && bus.out_ready;

    // Select the result for this beat; ACC ops combine with the previous result.
    always_comb begin
        res = bus.and_in;
        case (bus.op)
            OP_AND:     res = bus.and_in;
            OP_OR:      res = bus.or_in;
            OP_ACC_AND: res = acc_q & bus.and_in;
            OP_ACC_OR:  res = acc_q | bus.or_in;
            default:    res = bus.and_in;
        endcase
    end

    // Accumulator follows every accepted result and holds otherwise.
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = res;
        end
    end

    // Retired counter saturates at all-ones instead of wrapping.
    always_comb begin
        retired_d = retired_q;
        if (retire && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + 1'b1;
        end
    end

    // Accumulator and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            retired_q <= '0;
        end else begin
            acc_q     <= acc_d;
            retired_q <= retired_d;
        end
    end

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .pop       (retire),
        .din       (res),
        .dout      (fifo_dout),
        .occupancy (fifo_occ),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.out_data  = fifo_dout;
    assign bus.out_zero  = (fifo_dout == '0);
    assign bus.occupancy = fifo_occ;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// Directed bench for logic_result_stage: a main instance for function checks
// and a narrow-counter instance to reach retired-count saturation quickly.
module tb_logic_result_stage;
    import logic_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic_result_stage_if #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut_if ();
    logic_result_stage_if #(.WIDTH(32), .DEPTH(2), .CNT_W(3))  sat_if ();

    logic_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    logic_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(3)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_if.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] sb_q [$];
    logic [31:0] rnd;

    // one line per retired result of the main instance
    always @(posedge clk) begin
        if (!reset && dut_if.out_valid && dut_if.out_ready) begin
            $display("retire data=%08h zero=%0b retired_before=%0d",
                     dut_if.out_data, dut_if.out_zero, dut_if.retired);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        dut_if.in_valid = 1'b1;
        dut_if.op       = o;
        dut_if.and_in   = a;
        dut_if.or_in    = b;
    endtask

    initial begin
        reset            = 1'b1;
        dut_if.in_valid  = 1'b0;
        dut_if.op        = 2'b00;
        dut_if.and_in    = '0;
        dut_if.or_in     = '0;
        dut_if.out_ready = 1'b0;
        sat_if.in_valid  = 1'b0;
        sat_if.op        = 2'b00;
        sat_if.and_in    = '0;
        sat_if.or_in     = '0;
        sat_if.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_in_ready",  32'(dut_if.in_ready),  32'd1);
        check("rst_out_valid", 32'(dut_if.out_valid), 32'd0);
        check("rst_out_data",  dut_if.out_data,       32'h0);
        check("rst_out_zero",  32'(dut_if.out_zero),  32'd1);
        check("rst_occ",       32'(dut_if.occupancy), 32'd0);
        check("rst_retired",   32'(dut_if.retired),   32'd0);

        // single beat, visible one cycle after acceptance
        dut_if.out_ready = 1'b1;
        beat(OP_AND, 32'h0000A5A5, 32'hDEAD0000);
        tick();
        dut_if.in_valid = 1'b0;
        check("single_valid", 32'(dut_if.out_valid), 32'd1);
        check("single_data",  dut_if.out_data,       32'h0000A5A5);
        check("single_zero",  32'(dut_if.out_zero),  32'd0);
        check("single_ret0",  32'(dut_if.retired),   32'd0);
        tick();
        check("single_ret1",  32'(dut_if.retired),   32'd1);
        check("single_empty", 32'(dut_if.out_valid), 32'd0);

        // select / zero flag, held in FIFO then drained in order
        dut_if.out_ready = 1'b0;
        beat(OP_OR, 32'hFFFFFFFF, 32'h0);
        tick();
        beat(OP_AND, 32'h00005A5A, 32'h12345678);
        tick();
        dut_if.in_valid = 1'b0;
        check("sel_full_occ",   32'(dut_if.occupancy), 32'd2);
        check("sel_full_ready", 32'(dut_if.in_ready),  32'd0);
        check("sel_head0",      dut_if.out_data,       32'h0);
        check("sel_zero0",      32'(dut_if.out_zero),  32'd1);
        dut_if.out_ready = 1'b1;
        tick();
        check("sel_head1",      dut_if.out_data,       32'h00005A5A);
        check("sel_zero1",      32'(dut_if.out_zero),  32'd0);
        check("sel_occ1",       32'(dut_if.occupancy), 32'd1);
        tick();
        check("sel_ret",        32'(dut_if.retired),   32'd3);

        // accumulate chain
        beat(OP_OR, 32'h0, 32'h0000F0F0);
        tick();
        check("acc_r0", dut_if.out_data, 32'h0000F0F0);
        beat(OP_ACC_OR, 32'h0, 32'h00000F0F);
        tick();
        check("acc_r1", dut_if.out_data, 32'h0000FFFF);
        beat(OP_ACC_AND, 32'h000000FF, 32'h0);
        tick();
        check("acc_r2", dut_if.out_data, 32'h000000FF);
        dut_if.in_valid = 1'b0;
        tick();
        check("acc_ret", 32'(dut_if.retired), 32'd6);

        // backpressure: 1,2 accepted, 3 held while full
        dut_if.out_ready = 1'b0;
        beat(OP_AND, 32'd1, 32'h0);
        tick();
        beat(OP_AND, 32'd2, 32'h0);
        tick();
        check("bp_ready_full", 32'(dut_if.in_ready),  32'd0);
        check("bp_occ_full",   32'(dut_if.occupancy), 32'd2);
        beat(OP_AND, 32'd3, 32'h0);
        tick();
        check("bp_held_occ",   32'(dut_if.occupancy), 32'd2);
        check("bp_head1",      dut_if.out_data,       32'd1);
        dut_if.out_ready = 1'b1;
        tick();
        check("bp_ready_back", 32'(dut_if.in_ready),  32'd1);
        check("bp_occ_pop",    32'(dut_if.occupancy), 32'd1);
        check("bp_head2",      dut_if.out_data,       32'd2);
        tick();
        dut_if.in_valid = 1'b0;
        check("bp_head3",      dut_if.out_data,       32'd3);
        check("bp_occ_pp",     32'(dut_if.occupancy), 32'd1);
        tick();
        check("bp_drained",    32'(dut_if.out_valid), 32'd0);
        check("bp_ret",        32'(dut_if.retired),   32'd9);

        // steady push+pop at occupancy 1 with random data
        dut_if.out_ready = 1'b0;
        rnd = $urandom;
        beat(OP_AND, rnd, 32'h0);
        sb_q.push_back(rnd);
        tick();
        dut_if.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("pp_occ",  32'(dut_if.occupancy), 32'd1);
            check("pp_data", dut_if.out_data,       sb_q[0]);
            rnd = $urandom;
            beat(OP_AND, rnd, 32'h0);
            sb_q.push_back(rnd);
            tick();
            void'(sb_q.pop_front());
        end
        dut_if.in_valid = 1'b0;
        check("pp_last", dut_if.out_data, sb_q[0]);
        tick();
        void'(sb_q.pop_front());
        check("pp_empty", 32'(dut_if.occupancy), 32'd0);
        check("pp_ret",   32'(dut_if.retired),   32'd20);

        // reset mid-stream with FIFO full and acc = 0000FFFF
        dut_if.out_ready = 1'b0;
        beat(OP_AND, 32'h0000FFFF, 32'h0);
        tick();
        beat(OP_OR, 32'h0, 32'h0000FFFF);
        tick();
        dut_if.in_valid = 1'b0;
        check("mr_occ_full", 32'(dut_if.occupancy), 32'd2);
        beat(OP_AND, 32'hCAFEBABE, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dut_if.in_valid = 1'b0;
        check("mr_valid",   32'(dut_if.out_valid), 32'd0);
        check("mr_occ",     32'(dut_if.occupancy), 32'd0);
        check("mr_ready",   32'(dut_if.in_ready),  32'd1);
        check("mr_retired", 32'(dut_if.retired),   32'd0);
        check("mr_data",    dut_if.out_data,       32'h0);
        dut_if.out_ready = 1'b1;
        beat(OP_ACC_OR, 32'h0, 32'h1);
        tick();
        dut_if.in_valid = 1'b0;
        check("mr_acc_valid", 32'(dut_if.out_valid), 32'd1);
        check("mr_acc_data",  dut_if.out_data,       32'h1);
        tick();

        // retired saturation on the 3-bit counter instance
        check("sat_start", 32'(sat_if.retired), 32'd0);
        sat_if.out_ready = 1'b1;
        sat_if.in_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sat_if.and_in = 32'(i + 1);
            tick();
        end
        // 7 pushes, 6 pops so far
        check("sat_six", 32'(sat_if.retired), 32'd6);
        for (int i = 0; i < 5; i++) begin
            sat_if.and_in = 32'(i + 100);
            tick();
        end
        sat_if.in_valid = 1'b0;
        tick();
        check("sat_hold", 32'(sat_if.retired), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
